// File: rtl/mc_mainctrl.sv
// Multicycle MIPS main control FSM with a memory wait-timeout abort.
// Optional BNE support is compiled in when MC_BNE_EN is defined.
module mc_mainctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MC_BNE_EN
    ,S_BNE   = 4'd12
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_wait;
  logic          timeout_hit;

  logic mem_req_s, memwrite_s, irwrite_s, pcwrite_s, regwrite_s;

  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);
  // mem_ready in the same cycle as the limit is a normal completion.
  assign timeout_hit = TO_EN && in_wait && !mem_ready && (cnt_q == TO_V);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // State changes out of a wait state only happen on mem_ready or timeout,
  // both of which clear the counter, so no separate change check is needed.
  always_comb begin
    cnt_d = '0;
    if (TO_EN && in_wait && !mem_ready && !timeout_hit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)        state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || timeout_hit) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_s  = 1'b0;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    pcwrite_s  = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    regwrite_s = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
`ifdef MC_BNE_EN
          OP_BNE:  illegal_op = 1'b0;
`endif
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        mem_req_s  = 1'b1;
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNE: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        branch_ne = 1'b1;
        pcsrc     = 2'b01;
      end
`endif
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Reset forces FETCH, whose Moore outputs would otherwise start an access.
  assign mem_req   = mem_req_s  & resetn;
  assign memwrite  = memwrite_s & resetn;
  assign irwrite   = irwrite_s  & resetn;
  assign pcwrite   = pcwrite_s  & resetn;
  assign regwrite  = regwrite_s & resetn;
  assign bus_err   = timeout_hit & resetn;
  assign state_dbg = state_q;

endmodule
